// File: rtl/tx_arbiter.sv
// Round-robin front end that shares one serial transmitter among NREQ requesters:
// arbitrate, load the winner's character, wait for charSent (or time out), report back.
module tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   reqData,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         error,
  output logic                    busy,
  output logic                    load,
  output logic                    transmitEnable,
  output logic [WIDTH-1:0]        parallelDataIn,
  input  logic                    charSent
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   chan_q, chan_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ok_q, ok_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              char_sent_q;

  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     cand;
  logic [PW-1:0]     chan_idx;

  // Search starts one past the last served requester, so it gets lowest priority next.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    chan_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (chan_q[i]) chan_idx = PW'(i);
    end
  end

  // NOTE: every variable gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    ok_d    = ok_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          chan_d          = '0;
          chan_d[win_idx] = 1'b1;
          data_d          = reqData[int'(win_idx)*WIDTH +: WIDTH];
          state_d         = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        // A level already high on entry is stale; only a fresh rise completes.
        if (charSent && !char_sent_q) begin
          ok_d    = 1'b1;
          state_d = S_FINISH;
        end else if (cnt_q == CNT_MAX) begin
          ok_d    = 1'b0;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FINISH: begin
        ptr_d   = chan_idx;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= PW'(NREQ - 1);
      chan_q      <= '0;
      cnt_q       <= '0;
      ok_q        <= 1'b0;
      data_q      <= '0;
      char_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      chan_q      <= chan_d;
      cnt_q       <= cnt_d;
      ok_q        <= ok_d;
      data_q      <= data_d;
      char_sent_q <= charSent;
    end
  end

  // Outputs decode registered state only, so reset clears them without waiting for a clock.
  always_comb begin
    grant          = (state_q == S_LOAD) ? chan_q : '0;
    done           = (state_q == S_FINISH && ok_q) ? chan_q : '0;
    error          = (state_q == S_FINISH && !ok_q) ? chan_q : '0;
    busy           = (state_q != S_IDLE);
    load           = (state_q == S_LOAD);
    transmitEnable = (state_q == S_LOAD) || (state_q == S_SEND);
    parallelDataIn = data_q;
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: stimulus pushes expected grant/done/error events,
// an independent negedge monitor pops and compares them as the DUT presents them.
module tb_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] reqData = '0;
  logic                  charSent = 1'b0;
  logic [NREQ-1:0]       grant, done, error;
  logic                  busy, load, transmitEnable;
  logic [WIDTH-1:0]      parallelDataIn;

  tx_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .reqData        (reqData),
    .grant          (grant),
    .done           (done),
    .error          (error),
    .busy           (busy),
    .load           (load),
    .transmitEnable (transmitEnable),
    .parallelDataIn (parallelDataIn),
    .charSent       (charSent)
  );

  always #5 clk = ~clk;

  typedef enum {EV_GRANT, EV_DONE, EV_ERROR} ev_e;
  typedef struct {
    ev_e             kind;
    logic [NREQ-1:0] chan;
    logic [WIDTH-1:0] data;
    int              gap;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   cyc      = 0;
  int   grant_cyc = 0;
  logic [WIDTH-1:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_serve(input logic [NREQ-1:0] ch, input logic [WIDTH-1:0] d,
                           input int gap, input bit ok);
    exp_t e;
    e.kind = EV_GRANT; e.chan = ch; e.data = d; e.gap = 0;
    sb_q.push_back(e);
    e.kind = ok ? EV_DONE : EV_ERROR; e.data = '0; e.gap = gap;
    sb_q.push_back(e);
  endtask

  // Monitor: pops one expected event per presented grant/done/error.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      if (transmitEnable && !load)
        check("pdi_hold", parallelDataIn, last_data);
      if ((grant | done | error) != '0) begin
        check("exclusive", int'(grant != '0) + int'(done != '0) + int'(error != '0), 1);
        if (sb_q.size() == 0) begin
          check("unexpected_output", {grant, done, error}, '0);
        end else begin
          e = sb_q.pop_front();
          case (e.kind)
            EV_GRANT: begin
              check("grant", grant, e.chan);
              check("grant_data", parallelDataIn, e.data);
              check("grant_ctl", {load, transmitEnable, busy}, 3'b111);
              grant_cyc = cyc;
              last_data = parallelDataIn;
            end
            EV_DONE: begin
              check("done", {done, error}, {e.chan, 4'b0000});
              check("done_latency", cyc - grant_cyc, e.gap);
            end
            default: begin
              check("error", {done, error}, {4'b0000, e.chan});
              check("error_latency", cyc - grant_cyc, e.gap);
            end
          endcase
        end
      end
    end
  end

  task automatic wait_grant(output logic [NREQ-1:0] g);
    g = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (grant != '0) begin
        g = grant;
        return;
      end
    end
    n_checks++;
    n_errs++;
    $display("FAIL grant_wait: got no grant, expected one within 60 cycles (cycle %0d)", cyc);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    n_checks++;
    n_errs++;
    $display("FAIL idle_wait: got busy=1, expected 0 within 100 cycles (cycle %0d)", cyc);
  endtask

  // Call right after the grant negedge: fresh charSent rise d cycles into SEND.
  task automatic send(input int d);
    repeat (d) @(negedge clk);
    charSent = 1'b1;
    @(negedge clk);
    charSent = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, grant, '0);
    check({tag, "_done"}, done, '0);
    check({tag, "_error"}, error, '0);
    check({tag, "_ctl"}, {busy, load, transmitEnable}, 3'b000);
    check({tag, "_pdi"}, parallelDataIn, '0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish within 20000 cycles");
    $fatal(1);
  end

  initial begin : stimulus
    logic [NREQ-1:0] g;

    // Reset state
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Single request
    reqData[7:0] = 8'hAA;
    req = 4'b0001;
    exp_serve(4'b0001, 8'hAA, 4, 1'b1);
    wait_grant(g);
    req = '0;
    send(3);
    wait_idle();

    // All four at once from a fresh reset: served 0,1,2,3
    do_reset();
    reqData = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    exp_serve(4'b0001, 8'h11, 3, 1'b1);
    exp_serve(4'b0010, 8'h22, 3, 1'b1);
    exp_serve(4'b0100, 8'h33, 3, 1'b1);
    exp_serve(4'b1000, 8'h44, 3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      req &= ~g;
      send(2);
    end
    wait_idle();

    // Fairness: 0101 held, grants alternate
    reqData[7:0]   = 8'h55;
    reqData[23:16] = 8'h66;
    req = 4'b0101;
    exp_serve(4'b0001, 8'h55, 2, 1'b1);
    exp_serve(4'b0100, 8'h66, 2, 1'b1);
    exp_serve(4'b0001, 8'h55, 2, 1'b1);
    exp_serve(4'b0100, 8'h66, 2, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      if (k == 3) req = '0;
      send(1);
    end
    wait_idle();

    // Timeout: no charSent, error TIMEOUT+1 cycles after grant
    reqData[15:8] = 8'h77;
    req = 4'b0010;
    exp_serve(4'b0010, 8'h77, TIMEOUT + 1, 1'b0);
    wait_grant(g);
    req = '0;
    wait_idle();

    // Stale charSent; ptr=1 after timeout so requester 2 precedes 1
    charSent = 1'b1;
    reqData[23:16] = 8'h88;
    reqData[15:8]  = 8'h99;
    req = 4'b0110;
    exp_serve(4'b0100, 8'h88, 5, 1'b1);
    exp_serve(4'b0010, 8'h99, 2, 1'b1);
    wait_grant(g);
    req &= ~g;
    repeat (2) @(negedge clk);
    charSent = 1'b0;
    repeat (2) @(negedge clk);
    charSent = 1'b1;
    @(negedge clk);
    charSent = 1'b0;
    wait_grant(g);
    req &= ~g;
    send(1);
    wait_idle();

    // Reset mid-SEND: outputs clear asynchronously, no completion pulse
    reqData[31:24] = 8'hCC;
    req = 4'b1000;
    sb_q.push_back('{EV_GRANT, 4'b1000, 8'hCC, 0});
    wait_grant(g);
    req = '0;
    repeat (2) @(negedge clk);
    check("send_ctl", {busy, transmitEnable, load}, 3'b110);
    #2 rst = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    reqData[7:0]   = 8'hDD;
    reqData[31:24] = 8'hEE;
    req = 4'b1001;
    rst = 1'b1;
    exp_serve(4'b0001, 8'hDD, 2, 1'b1);
    exp_serve(4'b1000, 8'hEE, 2, 1'b1);
    for (int k = 0; k < 2; k++) begin
      wait_grant(g);
      req &= ~g;
      send(1);
    end
    wait_idle();

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

- Shares the single serial `transmit` datapath among `NREQ` requesters.
- Arbitrates among pending requests round-robin and captures the winner's byte.
- Drives the transmitter's `load`, `transmitEnable` and `parallelDataIn`, waits for `charSent`, then reports completion or timeout to the served requester.
- Sits between client logic and `transmit`; the `receive` side is untouched.

## Interface

- `NREQ`, 4: number of requesters (2..8).
- `WIDTH`, 8: character width; must match `transmit`.
- `TIMEOUT`, 4096: max `clk` cycles in SEND before abort.

Ports:

- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req` in NREQ: level request per requester.
- `reqData` in NREQ*WIDTH: requester i's byte at bits [i*WIDTH +: WIDTH].
- `grant` out NREQ: one-hot, high for exactly the LOAD cycle of the served requester.
- `done` out NREQ: one-hot, one-cycle pulse when character sent.
- `error` out NREQ: one-hot, one-cycle pulse on timeout.
- `busy` out 1: high in every state except IDLE.
- `load` out 1: to `transmit.load`.
- `transmitEnable` out 1: to `transmit.transmitEnable`.
- `parallelDataIn` out WIDTH: to `transmit.parallelDataIn`; registered.
- `charSent` in 1: from `transmit`; sampled on `clk`.

## Operation

- FSM states: IDLE, LOAD, SEND, FINISH.
- IDLE:
  - If any `req` bit is high, select the winner by round-robin starting at `ptr+1` mod NREQ.
  - Capture the winner's `reqData` into `parallelDataIn`, latch the one-hot `chan`, go to LOAD.
  - If no `req` bit is high, stay in IDLE.
- LOAD (exactly 1 cycle):
  - `load`=1, `transmitEnable`=1, `grant`=`chan`.
  - Clear the timeout counter; go to SEND.
- SEND:
  - `transmitEnable`=1, `load`=0.
  - On a `charSent` rising edge (`charSent`=1 and `charSentQ`=0), set `ok`=1 and go to FINISH.
  - If instead counter = TIMEOUT-1, set `ok`=0 and go to FINISH.
  - Otherwise increment the counter.
- FINISH (1 cycle):
  - `transmitEnable`=0.
  - `done`=`chan` if `ok`; `error`=`chan` if not.
  - Set `ptr` to the index of `chan`; go to IDLE.
- Edge detector: `charSentQ` registers `charSent` every cycle, in all states. A `charSent` already high on entry to SEND does not count; a fresh 0→1 rise is required.
- Round-robin: `ptr` resets to NREQ-1, so requester 0 wins first after reset. `ptr` advances on both done and error.
- Requester contract:
  - Hold `req` and `reqData` stable until `grant`.
  - Deassert `req` in the `grant` cycle unless another character is wanted.
  - A `req` still high at the next IDLE is served again in turn.
- Counter width is $clog2(TIMEOUT); no wrap is possible because SEND exits at TIMEOUT-1.
- Reset (async, any state, including mid-SEND):
  - State becomes IDLE; `ptr` becomes NREQ-1.
  - `chan`, counter, `charSentQ` and `ok` become 0.
  - All outputs become 0: `grant`, `done`, `error`, `busy`, `load`, `transmitEnable`, `parallelDataIn`.
  - No `done`/`error` pulse is issued for the aborted character.

## Timing

- Request seen in IDLE at cycle N:
  - `grant`/`load` high at N+1.
  - SEND from N+2.
- `charSent` rise sampled at cycle M: `done` at M+1, IDLE at M+2. The earliest next arbitration is at M+2.
- Minimum service time is 4 cycles: IDLE, LOAD, SEND, FINISH.
- Timeout case: SEND occupies TIMEOUT cycles (N+2 .. N+TIMEOUT+1); `error` pulses at N+TIMEOUT+2.
- `done`, `error` and `grant` are never high simultaneously. At most one bit of each is set.
- `parallelDataIn` holds its value from LOAD until the next capture. It does not change during SEND.

## Test plan

- Single request: `req`=0001, `reqData[7:0]`=8'hAA, real `transmit` + `receive` instances → `grant`=0001 for 1 cycle, `load` pulse, `done`=0001 after `charSent` rise, receiver `parallelDataOut`=8'hAA.
- All four request together, bytes 8'h11/22/33/44, each dropping `req` on `grant` → service order 0,1,2,3; receiver outputs 11,22,33,44 in order.
- Fairness: `req`=0101 held permanently → grants alternate 0001, 0100, 0001, 0100; requester 0 is never served twice in a row.
- Timeout: `TIMEOUT`=16, `charSent` tied 0, `req`=0010 → `error`=0010 exactly 16 SEND cycles after LOAD, no `done`, back to IDLE, `ptr`=1.
- Stale `charSent`: `charSent` held 1 entering SEND, falls, then rises → `done` only one cycle after the fresh rise.
- Reset mid-SEND: assert `rst`=0 while in SEND with `req`=1000 → all outputs 0 immediately (async). After release, `req`=1001 → requester 0 granted first.
